// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the trace capture buffer: register map, bit
// positions, trace word width and small helpers.
package wb_trace_buffer_pkg;

  localparam int TRACE_W = 36;

  // Word offsets, decoded from wb_adr_i[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_DATA_LO = 3'd2;
  localparam logic [2:0] REG_DATA_HI = 3'd3;
  localparam logic [2:0] REG_DROPPED = 3'd4;

  // CTRL bits
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bits
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_TRAPPED   = 3;

  typedef struct packed {
    logic irq_en;
    logic stop_on_trap;
    logic enable;
  } ctrl_t;

  // Saturating increment for the dropped-word counter
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_fifo.sv
// Synchronous circular FIFO with a registered show-ahead head. The memory
// has a single write port and a single registered read port so it maps to
// block RAM; the read address is the next-cycle read pointer, with a bypass
// for a word written into the slot that becomes the head.
module trace_fifo #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      head_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign head_o  = head_q;

  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;
  assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Registered head read at the next read pointer, bypassing a same-cycle write
  always_ff @(posedge clk_i) begin
    if (push_ok && (wr_ptr_q == rd_ptr_d)) head_q <= push_data_i;
    else                                   head_q <= mem_q[rd_ptr_d];
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Trace capture buffer: Wishbone B4 classic slave in front of a trace FIFO,
// with capture control, trap freeze, overflow accounting and an interrupt.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2   = 8,
  parameter bit STOP_ON_TRAP = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               trace_valid_i,
  input  logic [TRACE_W-1:0] trace_data_i,
  input  logic               trap_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               irq_o
);

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               pop_pend_q, pop_pend_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               ovf_q, ovf_d;
  logic               trapped_q, trapped_d;
  logic [31:0]        dropped_q, dropped_d;
  logic               irq_q, irq_d;

  logic               bus_req, wr_req, rd_req, clear, push_req, drop;
  logic [2:0]         reg_off;
  logic [31:0]        rdata;
  logic [TRACE_W-1:0] fifo_head;
  logic               fifo_empty, fifo_full;
  logic [DEPTH_LOG2:0] fifo_count;
  logic               unused_bits;

  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:4]};

  assign bus_req  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_req   = bus_req & wb_we_i & wb_sel_i[0];
  assign rd_req   = bus_req & ~wb_we_i;
  assign reg_off  = wb_adr_i[4:2];
  assign clear    = wr_req && (reg_off == REG_CTRL) && wb_dat_i[CTRL_CLEAR];
  // The freeze uses the registered TRAPPED, so a word arriving with trap_i is kept
  assign push_req = trace_valid_i & ctrl_q.enable & ~(trapped_q & ctrl_q.stop_on_trap);
  // pop_pend_q is only set when the head existed at request time
  assign drop     = push_req & ~clear & fifo_full & ~pop_pend_q;

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

  trace_fifo #(
    .WIDTH      (TRACE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_req),
    .push_data_i (trace_data_i),
    .pop_i       (pop_pend_q),
    .clear_i     (clear),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // Register read multiplexer; unmapped offsets read zero
  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_CTRL: begin
        rdata[CTRL_ENABLE] = ctrl_q.enable;
        rdata[CTRL_STOP]   = ctrl_q.stop_on_trap;
        rdata[CTRL_IRQ_EN] = ctrl_q.irq_en;
      end
      REG_STATUS: begin
        rdata[ST_EMPTY]    = fifo_empty;
        rdata[ST_FULL]     = fifo_full;
        rdata[ST_OVERFLOW] = ovf_q;
        rdata[ST_TRAPPED]  = trapped_q;
        rdata[31:16]       = 16'(fifo_count);
      end
      REG_DATA_LO: if (!fifo_empty) rdata = fifo_head[31:0];
      REG_DATA_HI: if (!fifo_empty) rdata[3:0] = fifo_head[35:32];
      REG_DROPPED: rdata = dropped_q;
      default:     rdata = '0;
    endcase
  end

  // Bus handshake, register writes, sticky flags and counter next state
  always_comb begin
    ack_d      = bus_req;
    dat_d      = bus_req ? rdata : 32'd0;
    pop_pend_d = rd_req && (reg_off == REG_DATA_HI) && !fifo_empty;
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    trapped_d  = trapped_q;
    dropped_d  = dropped_q;
    irq_d      = ctrl_q.irq_en & (fifo_full | ovf_q | trapped_q);

    if (wr_req && (reg_off == REG_CTRL)) begin
      ctrl_d.enable       = wb_dat_i[CTRL_ENABLE];
      ctrl_d.stop_on_trap = wb_dat_i[CTRL_STOP];
      ctrl_d.irq_en       = wb_dat_i[CTRL_IRQ_EN];
    end

    if (clear) begin
      ovf_d     = 1'b0;
      trapped_d = 1'b0;
      dropped_d = '0;
    end else begin
      // A new event wins over a same-cycle W1C
      if (drop)
        ovf_d = 1'b1;
      else if (wr_req && (reg_off == REG_STATUS) && wb_dat_i[ST_OVERFLOW])
        ovf_d = 1'b0;

      if (trap_i)
        trapped_d = 1'b1;
      else if (wr_req && (reg_off == REG_STATUS) && wb_dat_i[ST_TRAPPED])
        trapped_d = 1'b0;

      // A write to DROPPED wins over a same-cycle drop
      if (wr_req && (reg_off == REG_DROPPED))
        dropped_d = '0;
      else if (drop)
        dropped_d = sat_inc32(dropped_q);
    end
  end

  // State register; reset drops an in-flight ack immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      pop_pend_q <= 1'b0;
      ctrl_q     <= '{irq_en: 1'b0, stop_on_trap: STOP_ON_TRAP, enable: 1'b0};
      ovf_q      <= 1'b0;
      trapped_q  <= 1'b0;
      dropped_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      pop_pend_q <= pop_pend_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      trapped_q  <= trapped_d;
      dropped_q  <= dropped_d;
      irq_q      <= irq_d;
    end
  end

endmodule
